// File: rtl/gigatron_pkg.sv
// Shared constants and types for the Gigatron IN-port host driver.
// Holds OUT/IN bus bit positions, the idle IN value and the driver FSM states.
package gigatron_pkg;

  localparam int OUT_VSYNC_BIT = 7;
  localparam int OUT_HSYNC_BIT = 6;

  localparam logic [7:0] IN_IDLE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } in_driver_state_t;

endpackage

// File: rtl/gigatron_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, synchronous active-low reset.
// Ports: push/push_data in, pop/pop_data out, full, empty, level.
module gigatron_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign level    = wptr - rptr;
  assign full     = (level == FULL_LVL);
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/gigatron_in_driver.sv
// Host-side driver for the Gigatron IN port: queues host bytes and shows each
// for HOLD_FRAMES vsync frames then GAP_FRAMES idle frames. Ports: i_clock,
// i_reset_n (sync, active-low), i_out (OUT reg), i_data/i_valid/o_ready host
// handshake, o_in (to core i_in), o_busy, o_level (FIFO occupancy).
module gigatron_in_driver
  import gigatron_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_FRAMES = 2,
  parameter int GAP_FRAMES  = 1
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic [7:0]             i_out,
  input  logic [7:0]             i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [7:0]             o_in,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int CMAX = (HOLD_FRAMES > GAP_FRAMES) ? HOLD_FRAMES : GAP_FRAMES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_FRAMES - 1);
  localparam logic [CW-1:0] GAP_LOAD  =
    (GAP_FRAMES > 0) ? CW'(GAP_FRAMES - 1) : '0;

  in_driver_state_t state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [7:0]       in_n;
  logic             vsync_q;
  logic             fe;
  logic             full;
  logic             empty;
  logic             pop;
  logic             take_next;
  logic [7:0]       pop_data;
  logic             unused_out;

  // hsync and the low OUT bits are reserved for a later bit-serial mode.
  assign unused_out = ^{i_out[OUT_HSYNC_BIT], i_out[5:0]};

  // vsync is active-low: a frame starts on its falling edge.
  assign fe = vsync_q && !i_out[OUT_VSYNC_BIT];

  assign o_ready = !full;
  assign o_busy  = (state != IDLE) || (o_level != '0);

  gigatron_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (i_clock),
    .rst_n     (i_reset_n),
    .push      (i_valid && o_ready),
    .push_data (i_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .level     (o_level)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      o_in    <= IN_IDLE;
      vsync_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      o_in    <= in_n;
      vsync_q <= i_out[OUT_VSYNC_BIT];
    end
  end

  // take_next: load the next queued byte, or fall back to IDLE when empty.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    in_n      = o_in;
    pop       = 1'b0;
    take_next = 1'b0;
    if (fe) begin
      unique case (state)
        IDLE: take_next = 1'b1;
        HOLD: begin
          if (cnt != '0) begin
            cnt_n = cnt - CNT_ONE;
          end else if (GAP_FRAMES > 0) begin
            state_n = GAP;
            cnt_n   = GAP_LOAD;
            in_n    = IN_IDLE;
          end else begin
            take_next = 1'b1;
          end
        end
        GAP: begin
          if (cnt != '0) cnt_n = cnt - CNT_ONE;
          else           take_next = 1'b1;
        end
        default: take_next = 1'b1;
      endcase
    end
    if (take_next) begin
      if (!empty) begin
        pop     = 1'b1;
        in_n    = pop_data;
        cnt_n   = HOLD_LOAD;
        state_n = HOLD;
      end else begin
        in_n    = IN_IDLE;
        state_n = IDLE;
      end
    end
  end

endmodule
